// File: rtl/sd_op_sequencer.sv
// Programmable Wishbone master running a small op program against the SDC register file.
// Optional macro SDC_WB_ERR_EN adds the sdc_wb_err_i bus-error input.
//
// state  | meaning
// IDLE   | waiting for start_i
// FETCH  | program RAM read of the op at pc
// DECODE | dispatch on the fetched opcode
// BUS    | Wishbone cycle in flight, watchdog running
// GAP    | idle spacing between poll reads
// ERR    | report abort and return to IDLE
module sd_op_sequencer #(
  parameter int ADR_W       = 8,
  parameter int DAT_W       = 32,
  parameter int PROG_DEPTH  = 32,
  parameter int ACK_TIMEOUT = 255,
  parameter int POLL_LIMIT  = 1023,
  parameter int POLL_GAP    = 15
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  input  logic                          prog_we_i,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_adr_i,
  input  logic [3+ADR_W+DAT_W-1:0]      prog_dat_i,
  input  logic                          start_i,
  input  logic [$clog2(PROG_DEPTH)-1:0] start_pc_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [1:0]                    err_code_o,
  output logic [$clog2(PROG_DEPTH)-1:0] err_pc_o,
  output logic [DAT_W-1:0]              rd_data_o,
  output logic [DAT_W-1:0]              sdc_wb_dat_o,
  input  logic [DAT_W-1:0]              sdc_wb_dat_i,
  output logic [ADR_W-1:0]              sdc_wb_adr_o,
  output logic [DAT_W/8-1:0]            sdc_wb_sel_o,
  output logic                          sdc_wb_we_o,
  output logic                          sdc_wb_cyc_o,
  output logic                          sdc_wb_stb_o,
  input  logic                          sdc_wb_ack_i
`ifdef SDC_WB_ERR_EN
  ,
  input  logic                          sdc_wb_err_i
`endif
);

  localparam int PC_W = $clog2(PROG_DEPTH);
  localparam int OP_W = 3 + ADR_W + DAT_W;
  localparam int WD_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int PL_W = (POLL_LIMIT > 0) ? $clog2(POLL_LIMIT + 1) : 1;
  localparam int GP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_POLL  = 3'd2;
  localparam logic [2:0] OP_JUMP  = 3'd3;
  localparam logic [2:0] OP_HALT  = 3'd4;

  localparam logic [WD_W-1:0] WD_LOAD  = WD_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [GP_W-1:0] GAP_LOAD = GP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_BUS, S_GAP, S_ERR
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [WD_W-1:0]   wd_cnt;
  logic [PL_W-1:0]   poll_left;
  logic [GP_W-1:0]   gap_cnt;
  logic [OP_W-1:0]   prog_ram [PROG_DEPTH];
  logic [OP_W-1:0]   op_q;
  logic [2:0]        op_code;
  logic [ADR_W-1:0]  op_adr;
  logic [DAT_W-1:0]  op_dat;
  logic              poll_miss;

  assign op_code   = op_q[OP_W-1 -: 3];
  assign op_adr    = op_q[DAT_W +: ADR_W];
  assign op_dat    = op_q[DAT_W-1:0];
  assign poll_miss = (op_code == OP_POLL) && ((sdc_wb_dat_i & op_dat) == '0);

  // pc and the RAM are frozen while busy, so op_q stays valid through BUS and GAP
  always_ff @(posedge wb_clk_i) begin
    if (prog_we_i && !busy_o) prog_ram[prog_adr_i] <= prog_dat_i;
    op_q <= prog_ram[pc];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state        <= S_IDLE;
      pc           <= '0;
      wd_cnt       <= '0;
      poll_left    <= '0;
      gap_cnt      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      err_code_o   <= 2'd0;
      err_pc_o     <= '0;
      rd_data_o    <= '0;
      sdc_wb_dat_o <= '0;
      sdc_wb_adr_o <= '0;
      sdc_wb_sel_o <= '1;
      sdc_wb_we_o  <= 1'b0;
      sdc_wb_cyc_o <= 1'b0;
      sdc_wb_stb_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            pc         <= start_pc_i;
            err_code_o <= 2'd0;
            busy_o     <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          wd_cnt    <= WD_LOAD;
          poll_left <= PL_W'(POLL_LIMIT);
          case (op_code)
            OP_WRITE, OP_READ, OP_POLL: begin
              sdc_wb_cyc_o <= 1'b1;
              sdc_wb_stb_o <= 1'b1;
              sdc_wb_we_o  <= (op_code == OP_WRITE);
              sdc_wb_adr_o <= op_adr;
              sdc_wb_dat_o <= op_dat;
              state        <= S_BUS;
            end
            OP_JUMP: begin
              pc    <= op_dat[PC_W-1:0];
              state <= S_FETCH;
            end
            OP_HALT: begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= S_IDLE;
            end
            default: begin
              err_code_o <= 2'd3;
              state      <= S_ERR;
            end
          endcase
        end
        S_BUS: begin
`ifdef SDC_WB_ERR_EN
          if (sdc_wb_err_i) begin
            sdc_wb_cyc_o <= 1'b0;
            sdc_wb_stb_o <= 1'b0;
            err_code_o   <= 2'd3;
            state        <= S_ERR;
          end else
`endif
          if (sdc_wb_ack_i) begin
            sdc_wb_cyc_o <= 1'b0;
            sdc_wb_stb_o <= 1'b0;
            if (poll_miss) begin
              if (poll_left == '0) begin
                err_code_o <= 2'd2;
                state      <= S_ERR;
              end else begin
                poll_left <= poll_left - PL_W'(1);
                gap_cnt   <= GAP_LOAD;
                state     <= S_GAP;
              end
            end else begin
              if (op_code != OP_WRITE) rd_data_o <= sdc_wb_dat_i;
              pc    <= pc + PC_W'(1);
              state <= S_FETCH;
            end
          end else if (wd_cnt == '0) begin
            sdc_wb_cyc_o <= 1'b0;
            sdc_wb_stb_o <= 1'b0;
            err_code_o   <= 2'd1;
            state        <= S_ERR;
          end else begin
            wd_cnt <= wd_cnt - WD_W'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            sdc_wb_cyc_o <= 1'b1;
            sdc_wb_stb_o <= 1'b1;
            wd_cnt       <= WD_LOAD;
            state        <= S_BUS;
          end else begin
            gap_cnt <= gap_cnt - GP_W'(1);
          end
        end
        S_ERR: begin
          err_pc_o <= pc;
          err_o    <= 1'b1;
          busy_o   <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_op_sequencer.sv
// Self-checking bench for sd_op_sequencer: vector table, directed corner cases and
// randomized programs checked against a program-walking reference model.
module tb_sd_op_sequencer;
  localparam int PD = 32;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        prog_we_i = 1'b0;
  logic [4:0]  prog_adr_i = '0;
  logic [42:0] prog_dat_i = '0;
  logic        start_i = 1'b0;
  logic [4:0]  start_pc_i = '0;
  logic        busy_o, done_o, err_o;
  logic [1:0]  err_code_o;
  logic [4:0]  err_pc_o;
  logic [31:0] rd_data_o, sdc_wb_dat_o, sdc_wb_dat_i;
  logic [7:0]  sdc_wb_adr_o;
  logic [3:0]  sdc_wb_sel_o;
  logic        sdc_wb_we_o, sdc_wb_cyc_o, sdc_wb_stb_o, sdc_wb_ack_i;

  sd_op_sequencer #(.ADR_W(8), .DAT_W(32), .PROG_DEPTH(PD), .ACK_TIMEOUT(8),
                    .POLL_LIMIT(3), .POLL_GAP(15)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .prog_we_i(prog_we_i),
    .prog_adr_i(prog_adr_i), .prog_dat_i(prog_dat_i), .start_i(start_i),
    .start_pc_i(start_pc_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .err_code_o(err_code_o), .err_pc_o(err_pc_o), .rd_data_o(rd_data_o),
    .sdc_wb_dat_o(sdc_wb_dat_o), .sdc_wb_dat_i(sdc_wb_dat_i), .sdc_wb_adr_o(sdc_wb_adr_o),
    .sdc_wb_sel_o(sdc_wb_sel_o), .sdc_wb_we_o(sdc_wb_we_o), .sdc_wb_cyc_o(sdc_wb_cyc_o),
    .sdc_wb_stb_o(sdc_wb_stb_o), .sdc_wb_ack_i(sdc_wb_ack_i)
`ifdef SDC_WB_ERR_EN
    , .sdc_wb_err_i(1'b0)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // slave model: programmable wait states, register at 0x34 answers 0 for a set number of reads
  logic [31:0] slv_mem [256] = '{default: 32'h0};
  int          slv_wait = 0;
  bit          slv_never = 1'b0;
  int          wcnt = 0;
  int          rd34 = 0, rd34_base = 0, pz_thresh = 0;
  int          cyc_n = 0;

  assign sdc_wb_ack_i = sdc_wb_cyc_o && sdc_wb_stb_o && !slv_never && (wcnt == slv_wait);
  assign sdc_wb_dat_i = (sdc_wb_adr_o == 8'h34) ? (((rd34 - rd34_base) < pz_thresh) ? 32'h0 : 32'h1)
                                                : slv_mem[sdc_wb_adr_o];

  always @(posedge wb_clk_i) begin
    cyc_n <= cyc_n + 1;
    wcnt  <= (sdc_wb_stb_o && !sdc_wb_ack_i) ? wcnt + 1 : 0;
    if (sdc_wb_stb_o && sdc_wb_ack_i && sdc_wb_we_o) slv_mem[sdc_wb_adr_o] <= sdc_wb_dat_o;
    if (sdc_wb_stb_o && sdc_wb_ack_i && !sdc_wb_we_o && sdc_wb_adr_o == 8'h34) rd34 <= rd34 + 1;
  end

  typedef struct { logic we; logic [7:0] adr; logic [31:0] dat; } txn_t;
  txn_t log_q[$];
  int   rise_q[$];
  int   done_cnt = 0, err_cnt = 0, stb_hi = 0;
  logic stb_prev = 1'b0;

  always @(negedge wb_clk_i) begin
    if (done_o) done_cnt <= done_cnt + 1;
    if (err_o) err_cnt <= err_cnt + 1;
    if (sdc_wb_stb_o) stb_hi <= stb_hi + 1;
    if (sdc_wb_stb_o && !stb_prev) rise_q.push_back(cyc_n);
    stb_prev <= sdc_wb_stb_o;
    if (sdc_wb_stb_o && sdc_wb_ack_i)
      log_q.push_back('{sdc_wb_we_o, sdc_wb_adr_o, sdc_wb_we_o ? sdc_wb_dat_o : sdc_wb_dat_i});
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [42:0] mk(input logic [2:0] op, input logic [7:0] a, input logic [31:0] d);
    return {op, a, d};
  endfunction

  task automatic load(input logic [4:0] s, input logic [42:0] w);
    @(negedge wb_clk_i);
    prog_we_i = 1'b1; prog_adr_i = s; prog_dat_i = w;
    @(negedge wb_clk_i);
    prog_we_i = 1'b0;
  endtask

  int t_start;
  task automatic run(input logic [4:0] spc, input int budget);
    int n;
    log_q.delete(); rise_q.delete();
    @(negedge wb_clk_i);
    start_pc_i = spc; start_i = 1'b1; t_start = cyc_n;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    n = 0;
    while (busy_o && n < budget) begin @(negedge wb_clk_i); n++; end
    chk("run_finishes", {63'b0, busy_o}, 64'd0);
    @(negedge wb_clk_i);
  endtask

  typedef struct {
    logic [2:0] op; logic [7:0] adr; logic [31:0] dat; int wt;
    logic [1:0] code; bit done; bit chk_rd; logic [31:0] rd; int ntx;
  } vec_t;
  vec_t vt[10];

  logic [31:0] mm [256];
  logic [42:0] prog [PD];
  txn_t        exp_q[$];

  initial begin
    int d0, e0, s0, L, pc, steps;
    logic [31:0] erd;
    bit has_rd;

    vt[0] = '{3'd0, 8'h10, 32'hAA,  0, 2'd0, 1, 0, 32'h0,  1};
    vt[1] = '{3'd1, 8'h10, 32'h0,   2, 2'd0, 1, 1, 32'hAA, 1};
    vt[2] = '{3'd1, 8'h10, 32'h0,   7, 2'd0, 1, 1, 32'hAA, 1};
    vt[3] = '{3'd1, 8'h11, 32'h0,   8, 2'd1, 0, 0, 32'h0,  0};
    vt[4] = '{3'd6, 8'h10, 32'h0,   0, 2'd3, 0, 0, 32'h0,  0};
    vt[5] = '{3'd7, 8'h10, 32'h0,   0, 2'd3, 0, 0, 32'h0,  0};
    vt[6] = '{3'd4, 8'h00, 32'h0,   0, 2'd0, 1, 0, 32'h0,  0};
    vt[7] = '{3'd0, 8'h12, 32'h30,  1, 2'd0, 1, 0, 32'h0,  1};
    vt[8] = '{3'd2, 8'h12, 32'h10,  3, 2'd0, 1, 1, 32'h30, 1};
    vt[9] = '{3'd2, 8'h12, 32'h0F0, 0, 2'd0, 1, 1, 32'h30, 1};

    // reset values
    repeat (2) @(negedge wb_clk_i);
    chk("reset_ctrl", {56'b0, busy_o, done_o, err_o, sdc_wb_cyc_o, sdc_wb_stb_o, sdc_wb_we_o, err_code_o}, 64'd0);
    chk("reset_sel", {60'b0, sdc_wb_sel_o}, 64'hF);
    chk("reset_data", {rd_data_o, sdc_wb_dat_o}, 64'd0);
    chk("reset_adr_pc", {51'b0, sdc_wb_adr_o, err_pc_o}, 64'd0);
    wb_rst_ni = 1'b1;

    // write / read / halt with zero-wait slave
    load(0, mk(3'd0, 8'h24, 32'h7C)); load(1, mk(3'd1, 8'h24, 32'h0)); load(2, mk(3'd4, 8'h0, 32'h0));
    d0 = done_cnt;
    run(0, 200);
    chk("wr_rd_ntx", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("wr_txn", {log_q[0].we, log_q[0].adr, log_q[0].dat}, {1'b1, 8'h24, 32'h7C});
      chk("rd_txn", {log_q[1].we, log_q[1].adr, log_q[1].dat}, {1'b0, 8'h24, 32'h7C});
    end
    if (rise_q.size() > 0) chk("start_to_cyc", rise_q[0] - t_start, 3);
    else chk("start_to_cyc_seen", 0, 1);
    chk("wr_rd_done", done_cnt - d0, 1);
    chk("wr_rd_rdata", rd_data_o, 32'h7C);
    chk("wr_rd_code", err_code_o, 0);

    // poll succeeding on the fourth read
    load(0, mk(3'd2, 8'h34, 32'h1)); load(1, mk(3'd4, 8'h0, 32'h0));
    rd34_base = rd34; pz_thresh = 3; slv_wait = 0; d0 = done_cnt;
    run(0, 500);
    chk("poll_ntx", log_q.size(), 4);
    chk("poll_rises", rise_q.size(), 4);
    for (int i = 1; i < rise_q.size() && i < 4; i++) chk("poll_spacing", rise_q[i] - rise_q[i-1], 16);
    chk("poll_done", done_cnt - d0, 1);
    chk("poll_rdata", rd_data_o, 32'h1);

    // poll that never succeeds: 1 read + 3 retries, then code 2
    load(3, mk(3'd2, 8'h34, 32'h1));
    rd34_base = rd34; pz_thresh = 1000; d0 = done_cnt; e0 = err_cnt;
    run(3, 500);
    chk("plim_ntx", log_q.size(), 4);
    chk("plim_err", err_cnt - e0, 1);
    chk("plim_done", done_cnt - d0, 0);
    chk("plim_code", err_code_o, 2);
    chk("plim_pc", err_pc_o, 3);
    chk("plim_rdata_kept", rd_data_o, 32'h1);

    // slave never acks
    load(0, mk(3'd1, 8'h10, 32'h0));
    slv_never = 1'b1; s0 = stb_hi; e0 = err_cnt;
    run(0, 200);
    slv_never = 1'b0;
    chk("wd_stb_cycles", stb_hi - s0, 8);
    chk("wd_code", err_code_o, 1);
    chk("wd_err", err_cnt - e0, 1);
    chk("wd_pc", err_pc_o, 0);
    chk("wd_cyc_low", {62'b0, sdc_wb_cyc_o, sdc_wb_stb_o}, 0);

    // jump then halt; then illegal opcode in the target slot
    load(5, mk(3'd3, 8'h0, 32'hFFFF_FFE2)); load(2, mk(3'd4, 8'h0, 32'h0));
    d0 = done_cnt;
    run(5, 200);
    chk("jmp_ntx", log_q.size(), 0);
    chk("jmp_done", done_cnt - d0, 1);
    chk("jmp_code", err_code_o, 0);
    load(2, mk(3'd6, 8'h0, 32'h0));
    e0 = err_cnt;
    run(5, 200);
    chk("ill_code", err_code_o, 3);
    chk("ill_pc", err_pc_o, 2);
    chk("ill_err", err_cnt - e0, 1);

    // vector table: slot 0 = op, slot 1 = HALT
    load(1, mk(3'd4, 8'h0, 32'h0));
    foreach (vt[k]) begin
      load(0, mk(vt[k].op, vt[k].adr, vt[k].dat));
      slv_wait = vt[k].wt; d0 = done_cnt; e0 = err_cnt;
      run(0, 300);
      chk($sformatf("vec%0d_code", k), err_code_o, vt[k].code);
      chk($sformatf("vec%0d_done", k), done_cnt - d0, vt[k].done);
      chk($sformatf("vec%0d_err", k), err_cnt - e0, (vt[k].code != 0));
      chk($sformatf("vec%0d_ntx", k), log_q.size(), vt[k].ntx);
      if (vt[k].chk_rd) chk($sformatf("vec%0d_rd", k), rd_data_o, vt[k].rd);
    end
    slv_wait = 0;

    // self-loop: start and program writes are ignored while busy
    load(0, mk(3'd3, 8'h0, 32'h0)); load(3, mk(3'd0, 8'h20, 32'h5));
    log_q.delete();
    @(negedge wb_clk_i); start_pc_i = 0; start_i = 1'b1;
    @(negedge wb_clk_i); start_i = 1'b0;
    repeat (20) @(negedge wb_clk_i);
    chk("loop_busy", busy_o, 1);
    start_pc_i = 3; start_i = 1'b1;
    @(negedge wb_clk_i); start_i = 1'b0;
    prog_we_i = 1'b1; prog_adr_i = 0; prog_dat_i = mk(3'd4, 8'h0, 32'h0);
    @(negedge wb_clk_i); prog_we_i = 1'b0;
    repeat (20) @(negedge wb_clk_i);
    chk("loop_busy2", busy_o, 1);
    chk("loop_no_bus", log_q.size(), 0);
    wb_rst_ni = 1'b0; @(negedge wb_clk_i); wb_rst_ni = 1'b1;
    @(negedge wb_clk_i); start_pc_i = 0; start_i = 1'b1;
    @(negedge wb_clk_i); start_i = 1'b0;
    repeat (20) @(negedge wb_clk_i);
    chk("loop_write_ignored", busy_o, 1);
    wb_rst_ni = 1'b0; @(negedge wb_clk_i); wb_rst_ni = 1'b1;

    // reset in the middle of a bus cycle
    load(0, mk(3'd1, 8'h10, 32'h0)); load(1, mk(3'd4, 8'h0, 32'h0));
    slv_never = 1'b1;
    @(negedge wb_clk_i); start_pc_i = 0; start_i = 1'b1;
    @(negedge wb_clk_i); start_i = 1'b0;
    steps = 0;
    while (!sdc_wb_stb_o && steps < 20) begin @(negedge wb_clk_i); steps++; end
    chk("rst_mid_stb_seen", sdc_wb_stb_o, 1);
    d0 = done_cnt; e0 = err_cnt;
    #2 wb_rst_ni = 1'b0;
    #1;
    chk("rst_mid_ctrl", {56'b0, busy_o, done_o, err_o, sdc_wb_cyc_o, sdc_wb_stb_o, sdc_wb_we_o, err_code_o}, 0);
    chk("rst_mid_sel_adr", {52'b0, sdc_wb_sel_o, sdc_wb_adr_o}, {52'b0, 4'hF, 8'h0});
    chk("rst_mid_rdata", rd_data_o, 0);
    @(negedge wb_clk_i); wb_rst_ni = 1'b1; slv_never = 1'b0;
    repeat (5) @(negedge wb_clk_i);
    chk("rst_mid_no_pulse", {done_cnt - d0, err_cnt - e0}, 0);
    load(0, mk(3'd0, 8'h24, 32'h7C)); load(1, mk(3'd1, 8'h24, 32'h0)); load(2, mk(3'd4, 8'h0, 32'h0));
    d0 = done_cnt;
    run(0, 200);
    chk("post_rst_ntx", log_q.size(), 2);
    chk("post_rst_done", done_cnt - d0, 1);
    chk("post_rst_rdata", rd_data_o, 32'h7C);

    // randomized programs of WRITE/READ/forward JUMP against the reference model
    for (int it = 0; it < 40; it++) begin
      L = $urandom_range(3, 8);
      for (int i = 0; i < L; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 4)      prog[i] = mk(3'd0, 8'($urandom_range(0, 15)), $urandom);
        else if (r < 8) prog[i] = mk(3'd1, 8'($urandom_range(0, 15)), $urandom);
        else            prog[i] = mk(3'd3, 8'($urandom), ($urandom & 32'hFFFF_FFE0) | 32'($urandom_range(i + 1, L)));
      end
      prog[L] = mk(3'd4, 8'h0, 32'h0);
      for (int i = 0; i <= L; i++) load(5'(i), prog[i]);
      slv_wait = $urandom_range(0, 3);

      mm = slv_mem;
      exp_q.delete(); has_rd = 0; erd = '0; pc = 0; steps = 0;
      while (prog[pc][42:40] != 3'd4 && steps < 64) begin
        logic [7:0]  a;
        logic [31:0] d;
        a = prog[pc][39:32]; d = prog[pc][31:0];
        case (prog[pc][42:40])
          3'd0: begin exp_q.push_back('{1'b1, a, d}); mm[a] = d; pc++; end
          3'd1: begin exp_q.push_back('{1'b0, a, mm[a]}); erd = mm[a]; has_rd = 1; pc++; end
          default: pc = int'(d[4:0]);
        endcase
        steps++;
      end

      d0 = done_cnt;
      run(0, 1000);
      chk($sformatf("rnd%0d_ntx", it), log_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < log_q.size(); j++)
        chk($sformatf("rnd%0d_txn%0d", it, j), {log_q[j].we, log_q[j].adr, log_q[j].dat},
            {exp_q[j].we, exp_q[j].adr, exp_q[j].dat});
      chk($sformatf("rnd%0d_done", it), done_cnt - d0, 1);
      chk($sformatf("rnd%0d_code", it), err_code_o, 0);
      if (has_rd) chk($sformatf("rnd%0d_rd", it), rd_data_o, erd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
